// File: rtl/l1_l2_arbiter.sv
// Shares one L2 port between the L1I and L1D caches; one transaction at a time.
// Optional ARB_ROUND_ROBIN_EN: ties alternate by last_served instead of favouring D.
module l1_l2_arbiter #(
   parameter int TAG_W = 20,
   parameter int IDX_W = 6
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             read_I_arb,
   input  logic             write_I_arb,
   input  logic [IDX_W-1:0] index_I_arb,
   input  logic [TAG_W-1:0] tag_I_arb,
   input  logic [TAG_W-1:0] write_tag_I_arb,
   output logic             ready_arb_I,
   input  logic             read_D_arb,
   input  logic             write_D_arb,
   input  logic [IDX_W-1:0] index_D_arb,
   input  logic [TAG_W-1:0] tag_D_arb,
   input  logic [TAG_W-1:0] write_tag_D_arb,
   output logic             ready_arb_D,
   output logic             read_arb_L2,
   output logic             write_arb_L2,
   output logic [IDX_W-1:0] index_arb_L2,
   output logic [TAG_W-1:0] tag_arb_L2,
   output logic [TAG_W-1:0] write_tag_arb_L2,
   input  logic             ready_L2_arb,
   output logic [1:0]       grant,
   output logic             busy
);

   // state     | meaning
   // S_IDLE    | sample requests, arbitrate
   // S_GRANT_I | L1I owns L2, wait for ready_L2_arb
   // S_GRANT_D | L1D owns L2, wait for ready_L2_arb
   // S_RELEASE | one-cycle ready pulse to the owner, requests ignored
   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_GRANT_I = 2'b01,
      S_GRANT_D = 2'b10,
      S_RELEASE = 2'b11
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_last_served;
   logic               r_rd;
   logic               r_wr;
   logic [IDX_W-1:0]   r_idx;
   logic [TAG_W-1:0]   r_tag;
   logic [TAG_W-1:0]   r_wtag;
   logic               r_ready_I;
   logic               r_ready_D;
   logic               w_req_I;
   logic               w_req_D;
   logic               w_tie_D;
   logic               w_granted;

   assign w_req_I = read_I_arb | write_I_arb;
   assign w_req_D = read_D_arb | write_D_arb;

`ifdef ARB_ROUND_ROBIN_EN
   assign w_tie_D = ~r_last_served;
`else
   assign w_tie_D = 1'b1;
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_req_I && w_req_D)
               w_state_nxt = w_tie_D ? S_GRANT_D : S_GRANT_I;
            else if (w_req_I)
               w_state_nxt = S_GRANT_I;
            else if (w_req_D)
               w_state_nxt = S_GRANT_D;
         end
         S_GRANT_I, S_GRANT_D: begin
            if (ready_L2_arb)
               w_state_nxt = S_RELEASE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state       <= S_IDLE;
         r_last_served <= 1'b0;
         r_rd          <= 1'b0;
         r_wr          <= 1'b0;
         r_idx         <= '0;
         r_tag         <= '0;
         r_wtag        <= '0;
         r_ready_I     <= 1'b0;
         r_ready_D     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_ready_I <= (r_state == S_GRANT_I) && ready_L2_arb;
         r_ready_D <= (r_state == S_GRANT_D) && ready_L2_arb;
         // A write wins over a simultaneous read from the same requester.
         if (r_state == S_IDLE && w_state_nxt == S_GRANT_I) begin
            r_last_served <= 1'b0;
            r_rd          <= read_I_arb & ~write_I_arb;
            r_wr          <= write_I_arb;
            r_idx         <= index_I_arb;
            r_tag         <= tag_I_arb;
            r_wtag        <= write_tag_I_arb;
         end else if (r_state == S_IDLE && w_state_nxt == S_GRANT_D) begin
            r_last_served <= 1'b1;
            r_rd          <= read_D_arb & ~write_D_arb;
            r_wr          <= write_D_arb;
            r_idx         <= index_D_arb;
            r_tag         <= tag_D_arb;
            r_wtag        <= write_tag_D_arb;
         end
      end
   end

   assign w_granted        = (r_state == S_GRANT_I) || (r_state == S_GRANT_D);
   assign read_arb_L2      = w_granted & r_rd;
   assign write_arb_L2     = w_granted & r_wr;
   assign index_arb_L2     = r_idx;
   assign tag_arb_L2       = r_tag;
   assign write_tag_arb_L2 = r_wtag;
   assign ready_arb_I      = r_ready_I;
   assign ready_arb_D      = r_ready_D;
   assign grant            = {r_state == S_GRANT_D, r_state == S_GRANT_I};
   assign busy             = (r_state != S_IDLE);

endmodule
